// File: rtl/weight_gen_pkg.sv
// Shared definitions for the weight pattern generator.
//   WIDTH      : default output word width in bits
//   WW         : default weight field width, wide enough to hold 0..WIDTH
//   IDLE/EMIT/DONE : controller state encoding
package weight_gen_pkg;

  localparam int WIDTH = 16;
  localparam int WW    = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/next_comb.sv
// Combinational Gosper step: returns the next larger integer with the same
// popcount as x.
//   x    : current word (WIDTH bits)
//   next : next word of equal popcount (WIDTH bits); meaningless once x is
//          the MSB-packed word, which the controller never advances past
module next_comb #(
  parameter int WIDTH = weight_gen_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] lowbit_s;
  logic [WIDTH-1:0] ripple_s;

  // Index of the lowest set bit; zero input yields zero.
  function automatic int ctz(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        n = i;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Isolate the lowest one, ripple it upward, then refill the low ones.
  always_comb begin
    lowbit_s = x & ((~x) + {{(WIDTH-1){1'b0}}, 1'b1});
    ripple_s = x + lowbit_s;
    next     = (((ripple_s ^ x) >> 2) >> ctz(lowbit_s)) | ripple_s;
  end

endmodule

// File: rtl/weight_pattern_gen.sv
// Enumerates every WIDTH-bit word with exactly k ones in increasing order.
//   clk, rst_n         : clock and synchronous active-low reset
//   req_valid/ready    : request handshake, req_weight carries k
//   abort              : terminates the enumeration in progress
//   out_valid/ready    : output handshake for out_word/out_last
//   out_count          : words transferred in the current or last enumeration
//   err                : one-cycle pulse when k exceeds WIDTH
module weight_pattern_gen #(
  parameter int WIDTH = weight_gen_pkg::WIDTH,
  parameter int WW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WW-1:0]    req_weight,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_last,
  output logic [15:0]      out_count,
  output logic             err
);

  import weight_gen_pkg::*;

  logic [1:0]       state_r, state_s;
  logic [WW-1:0]    k_r, k_s;
  logic [WIDTH-1:0] word_r, word_s;
  logic             last_r, last_s;
  logic [15:0]      count_r, count_s;
  logic             valid_r, valid_s;
  logic             ready_r, ready_s;
  logic             err_r, err_s;
  logic [WIDTH-1:0] next_word_s;
  logic             xfer_s;

  // k ones packed at the LSB end: the first word of an enumeration.
  function automatic logic [WIDTH-1:0] ones_low(input logic [WW-1:0] kk);
    logic [WIDTH-1:0] all_v;
    all_v = '1;
    return ~(all_v << kk);
  endfunction

  // k ones packed at the MSB end: the final word of an enumeration.
  function automatic logic [WIDTH-1:0] ones_high(input logic [WW-1:0] kk);
    logic [WIDTH-1:0] all_v;
    all_v = '1;
    return all_v << (WIDTH - int'(kk));
  endfunction

  next_comb #(.WIDTH(WIDTH)) u_next (
    .x    (word_r),
    .next (next_word_s)
  );

  // Transfer qualifier for the output handshake.
  always_comb begin
    xfer_s = valid_r && out_ready;
  end

  // Next-state and next-output computation; abort outranks any transfer.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    word_s  = word_r;
    last_s  = last_r;
    count_s = count_r;
    valid_s = valid_r;
    ready_s = ready_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          if (int'(req_weight) <= WIDTH) begin
            state_s = EMIT;
            k_s     = req_weight;
            word_s  = ones_low(req_weight);
            last_s  = (ones_low(req_weight) == ones_high(req_weight));
            count_s = 16'd0;
            valid_s = 1'b1;
            ready_s = 1'b0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        // A transfer coinciding with abort still counts.
        if (xfer_s) begin
          count_s = count_r + 16'd1;
        end else begin
          count_s = count_r;
        end
        if (abort) begin
          state_s = IDLE;
          valid_s = 1'b0;
          ready_s = 1'b1;
        end else if (xfer_s) begin
          if (last_r) begin
            state_s = DONE;
            valid_s = 1'b0;
          end else begin
            word_s = next_word_s;
            last_s = (next_word_s == ones_high(k_r));
          end
        end else begin
          state_s = EMIT;
        end
      end
      DONE: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= {WW{1'b0}};
      word_r  <= {WIDTH{1'b0}};
      last_r  <= 1'b0;
      count_r <= 16'd0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      word_r  <= word_s;
      last_r  <= last_s;
      count_r <= count_s;
      valid_r <= valid_s;
      ready_r <= ready_s;
      err_r   <= err_s;
    end
  end

  assign req_ready = ready_r;
  assign out_valid = valid_r;
  assign out_word  = word_r;
  assign out_last  = last_r;
  assign out_count = count_r;
  assign err       = err_r;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Self-checking bench for weight_pattern_gen: a table of full enumerations
// checked against a brute-force next-equal-popcount model, plus directed
// sequences for backpressure, illegal weight, abort and mid-stream reset.
module tb_weight_pattern_gen;

  localparam int WIDTH = 16;
  localparam int WW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WW-1:0]    req_weight;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_last;
  logic [15:0]      out_count;
  logic             err;

  int total_checks  = 0;
  int passed_checks = 0;

  typedef struct {
    int          k;
    int          n;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  weight_pattern_gen #(.WIDTH(WIDTH), .WW(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_weight (req_weight),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_last   (out_last),
    .out_count  (out_count),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount(input logic [15:0] w);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      if (w[i]) c++;
    end
    return c;
  endfunction

  // Brute-force search for the next larger word of equal popcount.
  function automatic logic [15:0] next_pop(input logic [15:0] w, input int k);
    int v;
    logic [31:0] vv;
    v = int'(w) + 1;
    vv = v;
    while (v <= 65535 && popcount(vv[15:0]) != k) begin
      v++;
      vv = v;
    end
    return vv[15:0];
  endfunction

  task automatic run_enum(input vec_t v);
    logic [15:0] exp_w;
    logic [15:0] prev_w;
    logic [15:0] last_seen;
    int n, cyc, word_bad, last_bad, order_bad, gaps;
    bit done;
    n = 0; cyc = 0; word_bad = 0; last_bad = 0; order_bad = 0; gaps = 0;
    done = 1'b0; prev_w = 16'h0000; last_seen = 16'h0000;
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_weight = WW'(v.k);
    out_ready  = 1'b1;
    step();
    req_valid = 1'b0;
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_word", {16'd0, out_word}, {16'd0, v.first});
    check("count_cleared", {16'd0, out_count}, 32'd0);
    exp_w = v.first;
    while (!done && cyc < v.n + 8) begin
      if (out_valid) begin
        if (out_word !== exp_w || popcount(out_word) != v.k) word_bad++;
        if (n > 0 && out_word <= prev_w) order_bad++;
        if (out_last !== (n == v.n - 1)) last_bad++;
        prev_w = out_word;
        last_seen = out_word;
        if (out_last) done = 1'b1;
        else exp_w = next_pop(exp_w, v.k);
        n++;
      end else begin
        gaps++;
      end
      step();
      cyc++;
    end
    check("enum_finished", {31'd0, done}, 32'd1);
    check("word_total", n, v.n);
    check("word_model_errors", word_bad, 0);
    check("order_errors", order_bad, 0);
    check("last_flag_errors", last_bad, 0);
    check("valid_gaps", gaps, 0);
    check("last_word", {16'd0, last_seen}, {16'd0, v.last});
    check("done_count", {16'd0, out_count}, v.n);
    check("done_valid", {31'd0, out_valid}, 32'd0);
    check("done_ready", {31'd0, req_ready}, 32'd0);
    step();
    check("back_idle_ready", {31'd0, req_ready}, 32'd1);
    check("count_held", {16'd0, out_count}, v.n);
  endtask

  initial begin
    int bad;
    vecs[0] = '{k: 0,  n: 1,     first: 16'h0000, last: 16'h0000};
    vecs[1] = '{k: 1,  n: 16,    first: 16'h0001, last: 16'h8000};
    vecs[2] = '{k: 2,  n: 120,   first: 16'h0003, last: 16'hC000};
    vecs[3] = '{k: 16, n: 1,     first: 16'hFFFF, last: 16'hFFFF};
    vecs[4] = '{k: 15, n: 16,    first: 16'h7FFF, last: 16'hFFFE};
    vecs[5] = '{k: 8,  n: 12870, first: 16'h00FF, last: 16'hFF00};

    rst_n = 1'b0; req_valid = 1'b0; req_weight = 5'd0; abort = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_word", {16'd0, out_word}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_count", {16'd0, out_count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_enum(vecs[i]);
    end

    // Backpressure on the single k=16 word.
    out_ready = 1'b0; req_valid = 1'b1; req_weight = 5'd16;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_word", {16'd0, out_word}, 32'h0000FFFF);
      check("bp_last", {31'd0, out_last}, 32'd1);
      step();
    end
    check("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check("bp_count", {16'd0, out_count}, 32'd1);
    step();
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);

    // Illegal weight.
    req_valid = 1'b1; req_weight = 5'd17;
    step();
    req_valid = 1'b0;
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_no_valid", {31'd0, out_valid}, 32'd0);
    check("err_ready", {31'd0, req_ready}, 32'd1);
    step();
    check("err_cleared", {31'd0, err}, 32'd0);
    check("err_still_no_valid", {31'd0, out_valid}, 32'd0);
    check("err_ready2", {31'd0, req_ready}, 32'd1);

    // Abort in IDLE is ignored: the request is still accepted.
    abort = 1'b1; req_valid = 1'b1; req_weight = 5'd0; out_ready = 1'b0;
    step();
    abort = 1'b0; req_valid = 1'b0;
    check("idle_abort_valid", {31'd0, out_valid}, 32'd1);
    check("idle_abort_last", {31'd0, out_last}, 32'd1);
    out_ready = 1'b1;
    step();
    step();

    // Abort coinciding with the 5th transfer of k=8.
    req_valid = 1'b1; req_weight = 5'd8; out_ready = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_word5", {16'd0, out_word}, 32'h000001EF);
    check("abort_count4", {16'd0, out_count}, 32'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_count", {16'd0, out_count}, 32'd5);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b0) bad++;
      step();
    end
    check("abort_no_words", bad, 0);
    check("abort_count_held", {16'd0, out_count}, 32'd5);

    // Reset in the middle of a k=8 enumeration.
    req_valid = 1'b1; req_weight = 5'd8;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_word", {16'd0, out_word}, 32'd0);
    check("mrst_last", {31'd0, out_last}, 32'd0);
    check("mrst_count", {16'd0, out_count}, 32'd0);
    check("mrst_err", {31'd0, err}, 32'd0);
    check("mrst_ready", {31'd0, req_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    check("mrst_no_words", bad, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/weight_pattern_gen.md
WEIGHT_PATTERN_GEN -- requirements
Module: weight_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which sets the output word width in bits.
REQ-002 SHALL have parameter WW, default $clog2(WIDTH+1) (5), which sets the weight field width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a weight request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-007 SHALL have port req_weight, input, WW bits: the requested number of ones k.
REQ-008 SHALL have port abort, input, 1 bit: terminates the current enumeration.
REQ-009 SHALL have port out_valid, output, 1 bit: out_word is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_word.
REQ-011 SHALL have port out_word, output, WIDTH bits: a word with exactly k ones.
REQ-012 SHALL have port out_last, output, 1 bit: marks the final word of the enumeration.
REQ-013 SHALL have port out_count, output, 16 bits: the number of words transferred in the current or last enumeration.
REQ-014 SHALL have port err, output, 1 bit: a one-cycle pulse on an illegal weight.

Function
REQ-015 SHALL implement the states IDLE, EMIT and DONE; req_ready=1 only in IDLE.
REQ-016 SHALL, on acceptance (req_valid&&req_ready) with k<=WIDTH, latch k, load out_word=(1<<k)-1, clear out_count, and enter EMIT; out_valid is asserted the next cycle (latency 1).
REQ-017 SHALL, on acceptance with k>WIDTH, pulse err for exactly one cycle, never assert out_valid, and remain in IDLE.
REQ-018 SHALL assert out_valid=1 in EMIT and hold out_word and out_last stable until out_valid&&out_ready.
REQ-019 SHALL, on each transfer, increment out_count by 1 and advance out_word to the next larger integer of equal popcount (Gosper step: c=x&-x; r=x+c; next=(((r^x)>>2)>>ctz(c))|r).
REQ-020 SHALL assert out_last when out_word equals k ones packed at the MSB end; for k=0 the single word is 0x0000 and for k=WIDTH it is all-ones, each with out_last=1.
REQ-021 SHALL move from EMIT to DONE on a transfer with out_last=1, then to IDLE on the following cycle; out_count holds its value until the next acceptance.
REQ-022 SHALL give abort priority over all other events: from EMIT, the next state is IDLE and out_valid=0 the next cycle; a transfer in the abort cycle is counted; abort in IDLE or DONE has no effect.
REQ-023 SHALL emit exactly C(WIDTH,k) words per enumeration, in strictly increasing order, each with popcount k.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, enter IDLE with out_valid=0, out_word=0, out_last=0, out_count=0, err=0 and req_ready=1 on the next cycle.
REQ-025 SHALL, on reset during EMIT, discard the enumeration and emit no further words.

Structure
REQ-026 SHALL define WIDTH, WW and the state encoding (IDLE=0, EMIT=1, DONE=2) in the shared package weight_gen_pkg.
REQ-027 SHALL place the combinational Gosper step, including count-trailing-zeros, in the sub-module next_comb (x in, next out, WIDTH bits).

Verification
REQ-028 SHALL cover k=0: exactly one word, 0x0000, with out_last=1 and final out_count=1.
REQ-029 SHALL cover k=1 with out_ready held at 1: 16 words 0x0001, 0x0002 … 0x8000 on consecutive cycles, out_last only on 0x8000, and out_count=16.
REQ-030 SHALL cover k=2: the sequence 0x0003, 0x0005, 0x0006, 0x0009 …, 120 words in total, with the last word 0xC000; the scoreboard checks popcount=2 and strictly increasing values.
REQ-031 SHALL cover backpressure: with k=16, hold out_ready=0 for 3 cycles; 0xFFFF stays stable with out_last=1, and a single transfer follows when out_ready rises.
REQ-032 SHALL cover req_weight=17: err is high for one cycle, out_valid stays 0, and req_ready returns to 1.
REQ-033 SHALL cover abort and reset: with k=8, assert abort after the 5th transfer, giving out_count=5, IDLE, and no further words; then restart with k=8, drive rst_n=0 mid-stream, and require all outputs to reach reset values the next cycle.
